// File: rtl/lut_interp_reader.sv
// -----------------------------------------------------------------------------
// lut_interp_reader
//   Requesting side of the sin/tanh LUT read interface. Accepts an argument x,
//   issues a one-cycle read to the LUT and captures base/next/frac on the LUT
//   response. It then linearly interpolates
//     y = base + ((next - base) * frac) >>> FRAC_W
//   and saturates the result to signed 16 bits. Only one transaction is in
//   flight at a time. A watchdog abandons requests that the LUT never answers.
//
// Parameters
//   FRAC_W       width of lut_frac
//   TIMEOUT_CYC  WAIT cycles without lut_valid before abort (1..255)
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   in_valid   in_x valid
//   in_ready   block idle and out of reset, can accept in_x
//   in_x       signed Q15 LUT argument
//   lut_read   one-cycle read request to the LUT
//   lut_x      argument to the LUT, stable until the response or an abort
//   lut_valid  one-cycle LUT response strobe (honoured only in WAIT)
//   lut_base   LUT base sample (signed)
//   lut_next   LUT next sample (signed)
//   lut_frac   unsigned interpolation fraction
//   out_valid  out_y valid, held until out_ready
//   out_ready  downstream accepts out_y
//   out_y      signed interpolated result
//   timeout    one-cycle pulse when a request is aborted
// -----------------------------------------------------------------------------
module lut_interp_reader #(
   parameter int unsigned FRAC_W      = 4,
   parameter int unsigned TIMEOUT_CYC = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_x,
   output logic              lut_read,
   output logic [15:0]       lut_x,
   input  logic              lut_valid,
   input  logic [15:0]       lut_base,
   input  logic [15:0]       lut_next,
   input  logic [FRAC_W-1:0] lut_frac,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_y,
   output logic              timeout
);

   // Product width: 17-bit signed difference times (FRAC_W+1)-bit signed fraction.
   localparam int unsigned P_W = 18 + FRAC_W;

   localparam logic signed [P_W-1:0] C_MAX = P_W'(32767);
   localparam logic signed [P_W-1:0] C_MIN = P_W'(-32768);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_MUL,
      S_ADD,
      S_OUT
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [15:0]             r_x;
   logic [15:0]             r_base;
   logic [15:0]             r_next;
   logic [FRAC_W-1:0]       r_frac;
   logic signed [P_W-1:0]   r_prod;
   logic [7:0]              r_cnt;
   logic [15:0]             r_y;
   logic                    r_out_valid;
   logic                    r_timeout;

   logic                    w_accept;
   logic                    w_lut_hit;
   logic                    w_abort;
   logic signed [16:0]      w_diff;
   logic signed [P_W-1:0]   w_diff_x;
   logic signed [P_W-1:0]   w_frac_x;
   logic signed [P_W-1:0]   w_prod;
   logic signed [P_W-1:0]   w_base_x;
   logic signed [P_W-1:0]   w_sum;
   logic [15:0]             w_sat;

   assign in_ready  = (r_state == S_IDLE) & reset;
   assign lut_read  = (r_state == S_REQ);
   assign lut_x     = r_x;
   assign out_valid = r_out_valid;
   assign out_y     = r_y;
   assign timeout   = r_timeout;

   assign w_accept  = in_valid & in_ready;
   assign w_lut_hit = (r_state == S_WAIT) & lut_valid;
   // Abort on the WAIT cycle in which the counter would reach TIMEOUT_CYC.
   assign w_abort   = (r_state == S_WAIT) & ~lut_valid & (r_cnt == 8'(TIMEOUT_CYC - 1));

   // Interpolation datapath; everything is widened to P_W so the multiply is
   // exact and the arithmetic shift floors toward minus infinity.
   assign w_diff   = $signed({r_next[15], r_next}) - $signed({r_base[15], r_base});
   assign w_diff_x = $signed({{(P_W-17){w_diff[16]}}, w_diff});
   assign w_frac_x = $signed({{(P_W-FRAC_W){1'b0}}, r_frac});
   assign w_prod   = w_diff_x * w_frac_x;
   assign w_base_x = $signed({{(P_W-16){r_base[15]}}, r_base});
   assign w_sum    = w_base_x + (r_prod >>> FRAC_W);

   always_comb begin
      w_sat = w_sum[15:0];
      if (w_sum > C_MAX) begin
         w_sat = 16'h7FFF;
      end else if (w_sum < C_MIN) begin
         w_sat = 16'h8000;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept)  w_state_nxt = S_REQ;
         S_REQ:                 w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (w_lut_hit) begin
               w_state_nxt = S_MUL;
            end else if (w_abort) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_MUL:                 w_state_nxt = S_ADD;
         S_ADD:                 w_state_nxt = S_OUT;
         S_OUT:  if (out_ready) w_state_nxt = S_IDLE;
         default:               w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_x         <= '0;
         r_base      <= '0;
         r_next      <= '0;
         r_frac      <= '0;
         r_prod      <= '0;
         r_cnt       <= '0;
         r_y         <= '0;
         r_out_valid <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_timeout <= w_abort;

         if (w_accept) begin
            r_x <= in_x;
         end

         if (r_state == S_REQ) begin
            r_cnt <= '0;
         end else if ((r_state == S_WAIT) && !lut_valid) begin
            r_cnt <= r_cnt + 8'd1;
         end

         if (w_lut_hit) begin
            r_base <= lut_base;
            r_next <= lut_next;
            r_frac <= lut_frac;
         end

         if (r_state == S_MUL) begin
            r_prod <= w_prod;
         end

         if (r_state == S_ADD) begin
            r_y         <= w_sat;
            r_out_valid <= 1'b1;
         end else if ((r_state == S_OUT) && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lut_interp_reader.sv
// -----------------------------------------------------------------------------
// tb_lut_interp_reader
//   Directed bench for lut_interp_reader. The LUT side is driven inline: it
//   answers 5 cycles after lut_read, or never, depending on the step.
//   Expected results are hand-computed interpolation values.
// -----------------------------------------------------------------------------
module tb_lut_interp_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_x;
   logic        lut_read;
   logic [15:0] lut_x;
   logic        lut_valid;
   logic [15:0] lut_base;
   logic [15:0] lut_next;
   logic [3:0]  lut_frac;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_y;
   logic        timeout;

   int n_assert = 0;
   int n_fail   = 0;

   lut_interp_reader #(
      .FRAC_W      (4),
      .TIMEOUT_CYC (15)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .lut_read  (lut_read),
      .lut_x     (lut_x),
      .lut_valid (lut_valid),
      .lut_base  (lut_base),
      .lut_next  (lut_next),
      .lut_frac  (lut_frac),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept x; a bogus lut_valid is driven in the lut_read cycle and must be
   // ignored. Returns in the first WAIT cycle.
   task automatic accept_x(input logic [15:0] x, input string tag);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check({tag, " in_ready"}, 32'(in_ready), 1);
      in_x     = x;
      in_valid = 1'b1;
      tick();
      in_valid  = 1'b0;
      in_x      = ~x;
      lut_valid = 1'b1;
      lut_base  = 16'h7FFF;
      lut_next  = 16'h7FFF;
      lut_frac  = 4'hF;
      check({tag, " lut_read"}, 32'(lut_read), 1);
      check({tag, " lut_x"}, 32'(lut_x), 32'(x));
      tick();
      lut_valid = 1'b0;
      check({tag, " lut_read 1cyc"}, 32'(lut_read), 0);
      check({tag, " lut_x hold"}, 32'(lut_x), 32'(x));
   endtask

   // LUT answers in the 5th cycle after lut_read; afterwards the response
   // buses carry garbage that must not be picked up.
   task automatic lut_answer(input logic [15:0] b, input logic [15:0] nx,
                             input logic [3:0] f, input string tag);
      repeat (4) tick();
      lut_valid = 1'b1;
      lut_base  = b;
      lut_next  = nx;
      lut_frac  = f;
      tick();
      lut_valid = 1'b0;
      lut_base  = 16'h5555;
      lut_next  = 16'hAAAA;
      lut_frac  = 4'h5;
      check({tag, " ov E+0"}, 32'(out_valid), 0);
   endtask

   task automatic expect_out(input logic [15:0] exp_y, input string tag);
      tick();
      check({tag, " ov E+1"}, 32'(out_valid), 0);
      tick();
      check({tag, " ov E+2"}, 32'(out_valid), 1);
      check({tag, " out_y"}, $signed(out_y), $signed(exp_y));
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " ov drop"}, 32'(out_valid), 0);
      check({tag, " in_ready back"}, 32'(in_ready), 1);
   endtask

   task automatic run_txn(input logic [15:0] x, input logic [15:0] b,
                          input logic [15:0] nx, input logic [3:0] f,
                          input logic [15:0] exp_y, input string tag);
      accept_x(x, tag);
      lut_answer(b, nx, f, tag);
      expect_out(exp_y, tag);
      handshake(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int first_to;
      int pulses;
      int ov_cnt;
      int bad;

      reset     = 1'b0;
      in_valid  = 1'b0;
      in_x      = '0;
      lut_valid = 1'b0;
      lut_base  = '0;
      lut_next  = '0;
      lut_frac  = '0;
      out_ready = 1'b0;

      // Reset state, with in_valid asserted to show in_ready stays low
      repeat (3) tick();
      in_valid = 1'b1;
      in_x     = 16'h1111;
      tick();
      check("rst in_ready", 32'(in_ready), 0);
      check("rst lut_read", 32'(lut_read), 0);
      check("rst lut_x", 32'(lut_x), 0);
      check("rst out_valid", 32'(out_valid), 0);
      check("rst out_y", 32'(out_y), 0);
      check("rst timeout", 32'(timeout), 0);
      in_valid = 1'b0;
      #3 reset = 1'b1;
      tick();
      check("post-rst in_ready", 32'(in_ready), 1);

      // Main interpolation vectors
      run_txn(16'h0100, 16'd1000, 16'd2000, 4'd8, 16'd1500, "mid");
      run_txn(16'h0200, 16'd2000, 16'd1000, 4'd3, 16'd1812, "floor");
      run_txn(16'h8000, 16'h8000, 16'h7FFF, 4'd15, 16'd28671, "rise_full");
      run_txn(16'h7FFF, 16'h7FFF, 16'h8000, 4'd15, 16'h8FFF, "fall_full");
      run_txn(16'h0300, 16'd1234, 16'hFFFB, 4'd0, 16'd1234, "frac0");
      run_txn(16'h0000, 16'h0000, 16'h0000, 4'd0, 16'h0000, "tanh_mid");

      // LUT never answers; a late strobe after the abort is ignored
      accept_x(16'h0400, "to");
      first_to = -1;
      pulses   = 0;
      ov_cnt   = 0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         lut_valid = (n == 20);
         lut_base  = 16'd100;
         lut_next  = 16'd200;
         if (timeout === 1'b1) begin
            pulses++;
            if (first_to < 0) first_to = n;
         end
         if (out_valid !== 1'b0 || lut_read !== 1'b0) ov_cnt++;
      end
      lut_valid = 1'b0;
      check("to cycle", first_to, 15);
      check("to pulses", pulses, 1);
      check("to no out/read", ov_cnt, 0);
      check("to in_ready", 32'(in_ready), 1);
      run_txn(16'h0500, 16'd0, 16'd160, 4'd1, 16'd10, "after_to");

      // Output stall: held result, new input ignored, then back-to-back accept
      accept_x(16'h0AAA, "stall");
      lut_answer(16'd100, 16'd300, 4'd4, "stall");
      expect_out(16'd150, "stall");
      in_valid = 1'b1;
      in_x     = 16'h0BBB;
      bad      = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid !== 1'b1 || out_y !== 16'd150 || in_ready !== 1'b0 ||
             lut_read !== 1'b0 || lut_x !== 16'h0AAA) bad++;
      end
      check("stall hold", bad, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("stall ov drop", 32'(out_valid), 0);
      check("stall in_ready", 32'(in_ready), 1);
      check("stall no early read", 32'(lut_read), 0);
      tick();
      in_valid = 1'b0;
      check("b2b lut_read", 32'(lut_read), 1);
      check("b2b lut_x", 32'(lut_x), 32'(16'h0BBB));
      tick();
      check("b2b lut_read 1cyc", 32'(lut_read), 0);
      lut_answer(16'hFF9C, 16'd100, 4'd12, "b2b");
      expect_out(16'd50, "b2b");
      handshake("b2b");

      // Asynchronous reset while waiting on the LUT
      accept_x(16'h0600, "rst_wait");
      tick();
      #2 reset = 1'b0;
      #1;
      check("rst_wait lut_x", 32'(lut_x), 0);
      check("rst_wait in_ready", 32'(in_ready), 0);
      check("rst_wait lut_read", 32'(lut_read), 0);
      #3 reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid !== 1'b0 || timeout !== 1'b0 || lut_read !== 1'b0) bad++;
      end
      check("rst_wait quiet", bad, 0);
      check("rst_wait in_ready", 32'(in_ready), 1);

      // Asynchronous reset while holding a result
      accept_x(16'h0700, "rst_out");
      lut_answer(16'd1000, 16'd2000, 4'd8, "rst_out");
      expect_out(16'd1500, "rst_out");
      #2 reset = 1'b0;
      #1;
      check("rst_out ov", 32'(out_valid), 0);
      check("rst_out y", 32'(out_y), 0);
      check("rst_out lut_x", 32'(lut_x), 0);
      #3 reset = 1'b1;
      out_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (out_valid !== 1'b0) bad++;
      end
      out_ready = 1'b0;
      check("rst_out no stale", bad, 0);
      run_txn(16'h0800, 16'd100, 16'd300, 4'd4, 16'd150, "final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
